// File: rtl/tiny_eth_rx_deframer.sv
// MII receive deframer: strips preamble/SFD, packs nibbles into bytes, checks FCS and length,
// and reports a per-frame end/status strobe with good/bad frame counters.
module tiny_eth_rx_deframer #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic        rx_clk,
  input  logic        rst,
  input  logic [3:0]  rx_data,
  input  logic        rx_en,
  input  logic        rx_er,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_fcs_ok,
  output logic [3:0]  out_err,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  localparam int unsigned CW = $clog2(MAX_LEN + 2);
  localparam logic [CW-1:0] CntOver = CW'(MAX_LEN + 1);
  localparam logic [CW-1:0] CntMin  = CW'(MIN_LEN);
  localparam logic [CW-1:0] CntSat  = '1;
  localparam logic [31:0]   CrcPoly    = 32'hEDB88320;
  localparam logic [31:0]   CrcResidue = 32'hDEBB20E3;

  localparam logic [2:0] StDrop = 3'd0;
  localparam logic [2:0] StIdle = 3'd1;
  localparam logic [2:0] StPre  = 3'd2;
  localparam logic [2:0] StData = 3'd3;
  localparam logic [2:0] StOver = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   crc_q, crc_d;
  logic          phase_q, phase_d;
  logic [3:0]    low_q, low_d;
  logic          rxer_q, rxer_d;
  logic          first_q, first_d;
  logic [7:0]    out_data_d;
  logic          out_valid_d, out_sof_d, out_eof_d, out_fcs_ok_d;
  logic [3:0]    out_err_d;
  logic [15:0]   good_cnt_d, bad_cnt_d;
  logic [7:0]    byte_w;
  logic [CW-1:0] cnt_inc;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CrcPoly) : (r >> 1);
    end
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    crc_d        = crc_q;
    phase_d      = phase_q;
    low_d        = low_q;
    rxer_d       = rxer_q;
    first_d      = first_q;
    out_data_d   = out_data;
    out_valid_d  = 1'b0;
    out_sof_d    = 1'b0;
    out_eof_d    = 1'b0;
    out_fcs_ok_d = out_fcs_ok;
    out_err_d    = out_err;
    good_cnt_d   = good_cnt;
    bad_cnt_d    = bad_cnt;
    byte_w       = {rx_data, low_q};
    cnt_inc      = (cnt_q == CntSat) ? cnt_q : cnt_q + CW'(1);

    case (state_q)
      StDrop: begin
        if (!rx_en) state_d = StIdle;
      end
      StIdle: begin
        if (rx_en) state_d = (rx_data == 4'h5) ? StPre : StDrop;
      end
      StPre: begin
        if (!rx_en) begin
          state_d = StIdle;
        end else if (rx_data == 4'hD) begin
          state_d = StData;
          cnt_d   = '0;
          crc_d   = '1;
          phase_d = 1'b0;
          rxer_d  = 1'b0;
          first_d = 1'b1;
        end else if (rx_data != 4'h5) begin
          state_d = StDrop;
        end
      end
      StData: begin
        if (!rx_en) begin
          // A pending low nibble is reported as misalignment and never enters the CRC.
          out_eof_d    = 1'b1;
          out_fcs_ok_d = (crc_q == CrcResidue);
          out_err_d    = {1'b0, cnt_q < CntMin, phase_q, rxer_q | rx_er};
          state_d      = StIdle;
        end else begin
          if (rx_er) rxer_d = 1'b1;
          if (!phase_q) begin
            low_d   = rx_data;
            phase_d = 1'b1;
          end else begin
            phase_d     = 1'b0;
            out_data_d  = byte_w;
            out_valid_d = 1'b1;
            out_sof_d   = first_q;
            first_d     = 1'b0;
            crc_d       = crc_byte(crc_q, byte_w);
            cnt_d       = cnt_inc;
            if (cnt_inc == CntOver) state_d = StOver;
          end
        end
      end
      StOver: begin
        // Oversize byte was emitted last cycle; close the frame and ignore the rest.
        out_eof_d    = 1'b1;
        out_fcs_ok_d = (crc_q == CrcResidue);
        out_err_d    = {1'b1, cnt_q < CntMin, 1'b0, rxer_q};
        state_d      = StDrop;
      end
      default: state_d = StDrop;
    endcase

    if (out_eof) begin
      if (out_fcs_ok && (out_err == 4'h0)) good_cnt_d = good_cnt + 16'd1;
      else                                 bad_cnt_d  = bad_cnt + 16'd1;
    end
  end

  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StDrop;
      cnt_q      <= '0;
      crc_q      <= '1;
      phase_q    <= 1'b0;
      low_q      <= 4'h0;
      rxer_q     <= 1'b0;
      first_q    <= 1'b0;
      out_data   <= 8'h00;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      out_fcs_ok <= 1'b0;
      out_err    <= 4'h0;
      good_cnt   <= 16'h0000;
      bad_cnt    <= 16'h0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      crc_q      <= crc_d;
      phase_q    <= phase_d;
      low_q      <= low_d;
      rxer_q     <= rxer_d;
      first_q    <= first_d;
      out_data   <= out_data_d;
      out_valid  <= out_valid_d;
      out_sof    <= out_sof_d;
      out_eof    <= out_eof_d;
      out_fcs_ok <= out_fcs_ok_d;
      out_err    <= out_err_d;
      good_cnt   <= good_cnt_d;
      bad_cnt    <= bad_cnt_d;
    end
  end

endmodule

// File: tb/tb_tiny_eth_rx_deframer.sv
// Scoreboard bench for tiny_eth_rx_deframer: expected bytes and end-of-frame status are queued
// as nibbles are driven and popped as the DUT strobes them out.
module tb_tiny_eth_rx_deframer;

  localparam int unsigned MIN_LEN = 64;
  localparam int unsigned MAX_LEN = 1518;
  localparam int OVER = MAX_LEN + 1;

  logic        rx_clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rx_data = 4'h0;
  logic        rx_en = 1'b0;
  logic        rx_er = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid, out_sof, out_eof, out_fcs_ok;
  logic [3:0]  out_err;
  logic [15:0] good_cnt, bad_cnt;

  tiny_eth_rx_deframer #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .rx_clk    (rx_clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_en     (rx_en),
    .rx_er     (rx_er),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .out_fcs_ok(out_fcs_ok),
    .out_err   (out_err),
    .good_cnt  (good_cnt),
    .bad_cnt   (bad_cnt)
  );

  always #5 rx_clk = ~rx_clk;

  typedef struct {logic [7:0] data; logic sof;} byte_t;
  typedef struct {logic fcs_ok; logic [3:0] err;} eof_t;

  byte_t      exp_b[$];
  eof_t       exp_e[$];
  logic [7:0] frm[$];
  int         n_chk = 0;
  int         n_err = 0;
  int         exp_good = 0;
  int         exp_bad = 0;

  // Bit-serial reference CRC, LSB of each byte first.
  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ b[i];
      r  = {1'b0, r[31:1]};
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  task automatic build(input int len);
    logic [31:0] c;
    frm.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < len - 4; i++) begin
      frm.push_back(8'($urandom));
      c = ref_crc(c, frm[i]);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
  endtask

  // Advance one clock; outputs of the previous edge are scoreboarded at the falling edge.
  task automatic step(input logic en, input logic [3:0] d, input logic er);
    byte_t eb;
    eof_t  ee;
    rx_en = en;
    rx_data = d;
    rx_er = er;
    @(negedge rx_clk);
    if (out_valid) begin
      n_chk++;
      if (exp_b.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_byte: got data=%h sof=%b, expected no byte", out_data, out_sof);
      end else begin
        eb = exp_b.pop_front();
        if (out_data !== eb.data || out_sof !== eb.sof) begin
          n_err++;
          $display("FAIL byte: got data=%h sof=%b, expected data=%h sof=%b",
                   out_data, out_sof, eb.data, eb.sof);
        end
      end
    end
    if (out_eof) begin
      n_chk++;
      if (exp_e.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_eof: got fcs_ok=%b err=%b, expected no eof", out_fcs_ok, out_err);
      end else begin
        ee = exp_e.pop_front();
        if (out_fcs_ok !== ee.fcs_ok || out_err !== ee.err || out_valid !== 1'b0
            || exp_b.size() != 0) begin
          n_err++;
          $display("FAIL eof: got fcs_ok=%b err=%b valid=%b pending=%0d, expected fcs_ok=%b err=%b valid=0 pending=0",
                   out_fcs_ok, out_err, out_valid, exp_b.size(), ee.fcs_ok, ee.err);
        end
      end
    end
    @(posedge rx_clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (exp_b.size() != 0 || exp_e.size() != 0); i++) step(1'b0, 4'h0, 1'b0);
    repeat (3) step(1'b0, 4'h0, 1'b0);
    n_chk++;
    if (exp_b.size() != 0 || exp_e.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d bytes and %0d eofs outstanding, expected 0 and 0",
               exp_b.size(), exp_e.size());
      exp_b.delete();
      exp_e.delete();
    end
  endtask

  task automatic send_frame(input int extra, input int er_at, input logic ok, input logic [3:0] err);
    repeat (2) step(1'b0, 4'h0, 1'b0);
    repeat (15) step(1'b1, 4'h5, 1'b0);
    step(1'b1, 4'hD, 1'b0);
    for (int i = 0; i < frm.size(); i++) begin
      step(1'b1, frm[i][3:0], i == er_at);
      if (i < OVER) exp_b.push_back('{frm[i], i == 0});
      if (i == OVER - 1) exp_e.push_back('{ok, err});
      step(1'b1, frm[i][7:4], 1'b0);
    end
    if (extra != 0) step(1'b1, 4'hA, 1'b0);
    if (frm.size() < OVER) exp_e.push_back('{ok, err});
    drain();
  endtask

  task automatic check_counts(input string name);
    n_chk++;
    if (good_cnt !== 16'(exp_good) || bad_cnt !== 16'(exp_bad)) begin
      n_err++;
      $display("FAIL %s_counts: got good=%0d bad=%0d, expected good=%0d bad=%0d",
               name, good_cnt, bad_cnt, exp_good, exp_bad);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    n_chk++;
    if ({out_data, out_valid, out_sof, out_eof, out_fcs_ok, out_err, good_cnt, bad_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got data=%h v=%b sof=%b eof=%b ok=%b err=%b good=%0d bad=%0d, expected all 0",
               out_data, out_valid, out_sof, out_eof, out_fcs_ok, out_err, good_cnt, bad_cnt);
    end
    @(posedge rx_clk);
    #1 rst = 1'b1;
    step(1'b0, 4'h0, 1'b0);
  endtask

  task automatic test_min_good();
    build(64);
    send_frame(0, -1, 1'b1, 4'b0000);
    exp_good++;
    check_counts("min_good");
  endtask

  task automatic test_corrupt_fcs();
    build(64);
    frm[10] = frm[10] ^ 8'h04;
    send_frame(0, -1, 1'b0, 4'b0000);
    exp_bad++;
    check_counts("corrupt_fcs");
  endtask

  task automatic test_alignment();
    build(64);
    send_frame(1, -1, 1'b1, 4'b0010);
    exp_bad++;
    check_counts("alignment");
  endtask

  task automatic test_short_rx_er();
    build(40);
    send_frame(0, 17, 1'b1, 4'b0101);
    exp_bad++;
    check_counts("short_rx_er");
  endtask

  task automatic test_oversize();
    logic [31:0] c;
    frm.delete();
    for (int i = 0; i < 1600; i++) frm.push_back(8'($urandom));
    c = 32'hFFFFFFFF;
    for (int i = 0; i < OVER; i++) c = ref_crc(c, frm[i]);
    send_frame(0, -1, c == 32'hDEBB20E3, 4'b1000);
    exp_bad++;
    check_counts("oversize");
    build(100);
    send_frame(0, -1, 1'b1, 4'b0000);
    exp_good++;
    check_counts("after_oversize");
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] nib;
    build(64);
    repeat (2) step(1'b0, 4'h0, 1'b0);
    repeat (15) step(1'b1, 4'h5, 1'b0);
    step(1'b1, 4'hD, 1'b0);
    for (int k = 0; k < 128; k++) begin
      nib = k[0] ? frm[k / 2][7:4] : frm[k / 2][3:0];
      if (k == 41) begin
        rst = 1'b0;
        exp_b.delete();
        exp_e.delete();
        exp_good = 0;
        exp_bad = 0;
        #1;
        n_chk++;
        if ({out_data, out_valid, out_sof, out_eof, out_fcs_ok, out_err, good_cnt, bad_cnt} !== '0)
        begin
          n_err++;
          $display("FAIL mid_reset_outputs: got data=%h v=%b eof=%b ok=%b err=%b good=%0d bad=%0d, expected all 0",
                   out_data, out_valid, out_eof, out_fcs_ok, out_err, good_cnt, bad_cnt);
        end
      end
      if (k == 44) rst = 1'b1;
      if (k < 40 && k[0]) exp_b.push_back('{frm[k / 2], k == 1});
      step(1'b1, nib, 1'b0);
      if (k == 43) begin
        n_chk++;
        if ({out_valid, out_eof, good_cnt, bad_cnt} !== '0) begin
          n_err++;
          $display("FAIL held_reset_outputs: got v=%b eof=%b good=%0d bad=%0d, expected all 0",
                   out_valid, out_eof, good_cnt, bad_cnt);
        end
      end
    end
    drain();
    check_counts("reset_dropped");
    build(64);
    send_frame(0, -1, 1'b1, 4'b0000);
    exp_good++;
    check_counts("after_reset");
  endtask

  initial begin
    test_reset();
    check_counts("reset");
    test_min_good();
    test_corrupt_fcs();
    test_alignment();
    test_short_rx_er();
    test_oversize();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/tiny_eth_rx_deframer.md
# tiny_eth_rx_deframer

Receive-path deframer directly downstream of the MII nibble interface of `tiny_eth_mac`. It strips preamble/SFD, assembles nibbles into bytes, checks CRC-32 FCS and frame length, and presents a byte stream with a per-frame end/status strobe to the MAC client logic. The MII cannot stall, so the block has no backpressure: it emits at most one byte every two `rx_clk` cycles.

## Interface
- `MIN_LEN`, default 64: minimum legal frame length in bytes, DA through FCS inclusive.
- `MAX_LEN`, default 1518: maximum legal frame length in bytes, DA through FCS inclusive.

Ports:
- `rx_clk` in 1: MII receive clock; the only clock.
- `rst` in 1: reset, asynchronous, active-low.
- `rx_data` in 4: MII receive nibble.
- `rx_en` in 1: MII receive data valid.
- `rx_er` in 1: MII receive error.
- `out_data` out 8: received byte, DA through FCS; FCS bytes are included.
- `out_valid` out 1: one-cycle strobe, `out_data` valid.
- `out_sof` out 1: high with the first `out_valid` of a frame.
- `out_eof` out 1: one-cycle end-of-frame strobe, never coincident with `out_valid`.
- `out_fcs_ok` out 1: qualified by `out_eof`; CRC residue correct.
- `out_err` out 4: qualified by `out_eof`.
  - [0] rx_er seen
  - [1] alignment (odd nibble count)
  - [2] short
  - [3] long
- `good_cnt` out 16: count of frames ending with `out_fcs_ok`=1 and `out_err`=0; wraps.
- `bad_cnt` out 16: count of all other `out_eof` frames; wraps.

## Operation
- All outputs are registered. On reset every output is 0 and the state is DROP.
- States:
  - DROP
    - `rx_en`=0 → IDLE.
  - IDLE
    - `rx_en`=1 and `rx_data`=5 → PRE.
    - `rx_en`=1 with any other nibble → DROP.
  - PRE
    - `rx_en`=0 → IDLE, no `out_eof`.
    - Nibble 5 → stay.
    - Nibble D → DATA. Byte counter and CRC are cleared, and the nibble phase is set to low.
    - Any other nibble → DROP, no `out_eof`.
    - There is no minimum preamble length: one 5 followed by D is accepted.
  - DATA
    - Nibbles arrive low first, then high. The byte is `{high, low}`.
    - Each completed byte is emitted, CRC-updated, and counted.
    - `rx_en`=0 → emit `out_eof`, go to IDLE.
    - Byte count reaching `MAX_LEN`+1 → emit that byte, then on the next cycle emit `out_eof` with err[3]=1 and go to DROP.
- `rx_er`=1 on any DATA cycle sets a sticky err[0] for the frame. `rx_er` is ignored outside DATA.
- CRC-32:
  - Reflected polynomial 0xEDB88320, byte LSB first.
  - Register initialised to 0xFFFFFFFF at SFD, no final XOR.
  - `out_fcs_ok`=1 if and only if the register equals 0xDEBB20E3 after the last complete byte.
- At `out_eof`:
  - err[1]=1 if a low nibble is pending. The pending nibble is discarded and is not CRC'd.
  - err[2]=1 if the byte count is less than `MIN_LEN`.
  - err[3]=1 only on the oversize exit.
- The byte counter width is $clog2(`MAX_LEN`+2) and the counter saturates.
- `out_data` holds its last value when `out_valid`=0.
- `good_cnt`/`bad_cnt` update on the cycle after `out_eof`.

## Timing
- Low nibble sampled at edge N, high nibble at edge N+1 → `out_valid` high for the cycle after edge N+1. Latency is 1 cycle from the high nibble.
- `out_valid` pulses are at least 2 cycles apart. `out_sof` accompanies only the first `out_valid` after SFD.
- `rx_en` sampled low at edge M while in DATA → `out_eof` high for the cycle after edge M, with `out_fcs_ok`/`out_err` valid in that same cycle.
- If `rx_en` drops on the edge after a high nibble, `out_valid` (last byte) and `out_eof` occur in consecutive cycles.
- A new preamble sampled on the same edge as `out_eof` is processed normally: the IDLE transition happens that edge.
- Asynchronous reset mid-frame:
  - Outputs go to 0 immediately and no `out_eof` is produced.
  - After release the block sits in DROP until `rx_en` is sampled 0, so a frame in progress at release is ignored entirely.

## Test plan
- **Minimum good frame.** 15×nibble 5, D, then 60 payload bytes plus correct FCS (64 bytes).
  - Expect 64 `out_valid` with `out_sof` on the first and bytes matching the input.
  - Then `out_eof` with `out_fcs_ok`=1 and `out_err`=0.
  - `good_cnt`=1.
- **Corrupt FCS.** Same frame with one payload bit flipped.
  - Expect `out_fcs_ok`=0, `out_err`=0, `bad_cnt`=1.
- **Alignment error.** Good 64-byte frame plus 1 extra nibble before `rx_en` falls.
  - Expect 64 bytes out and `out_eof` with err=0010.
  - `out_fcs_ok`=1, since the extra nibble is discarded.
- **Short and rx_er.** 40-byte frame with valid FCS, with `rx_er` pulsed once mid-frame.
  - Expect 40 bytes out and `out_eof` with err=0101.
- **Oversize.** Continuous 1600-byte frame.
  - Expect exactly 1519 `out_valid`, then `out_eof` with err[3]=1.
  - No further output until `rx_en`=0.
  - A following good frame is received correctly.
- **Reset mid-frame.** Assert `rst` low for 3 cycles at byte 20 of a frame; `rx_en` stays high after release.
  - All outputs read 0 during reset.
  - No output for the remainder of that frame.
  - The next good frame yields `good_cnt`=1.
